// File: rtl/hit_detector_if.sv
// Bus between the board/light controller and the hit detector.
//   enable, clear_score : game control from the score logic
//   buttons             : raw mole buttons (asynchronous to clk)
//   lights              : lamp vector from the light controller
//   hit, miss           : one-cycle strike result pulses
//   hit_pos             : index of the last struck button
//   score, misses       : saturating hit/miss counters
interface hit_detector_if #(
    parameter int unsigned SCORE_W = 8
) ();
    logic               enable;
    logic               clear_score;
    logic [8:0]         buttons;
    logic [8:0]         lights;
    logic               hit;
    logic               miss;
    logic [3:0]         hit_pos;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] misses;

    // Board side: drives control and buttons, observes results
    modport master (
        output enable, clear_score, buttons, lights,
        input  hit, miss, hit_pos, score, misses
    );

    // Detector side
    modport slave (
        input  enable, clear_score, buttons, lights,
        output hit, miss, hit_pos, score, misses
    );
endinterface

// File: rtl/hit_detector.sv
// Whack-a-mole player input: synchronises and debounces the 9 mole buttons,
// judges each new press against the lit lamp and keeps saturating counters.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : hit_detector_if.slave (enable, clear_score, buttons, lights in;
//            hit, miss, hit_pos, score, misses out, all registered)
module hit_detector #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned SCORE_W         = 8,
    parameter bit          MISS_ON_IDLE    = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    hit_detector_if.slave  bus
);
    localparam int unsigned N_BTN = 9;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned POS_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [N_BTN-1:0]   sync1_q;
    logic [N_BTN-1:0]   sync2_q;
    logic [N_BTN-1:0]   deb_q;
    logic [N_BTN-1:0]   press_q;
    logic [CNT_W-1:0]   cnt_q [N_BTN];

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic               hit_d;
    logic               miss_d;
    logic               hit_q;
    logic               miss_q;
    logic [POS_W-1:0]   hit_pos_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] misses_q;

    // Lowest-index set bit of a press vector
    function automatic logic [POS_W-1:0] lowest_idx(input logic [N_BTN-1:0] v);
        logic [POS_W-1:0] r;
        r = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) r = POS_W'(i);
        end
        return r;
    endfunction

    // Two-flop synchroniser, debounce counters and rising-edge press pulses.
    // The counter only runs while synced and debounced levels disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.buttons;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]   <= '0;
                    deb_q[i]   <= sync2_q[i];
                    press_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Strike judgement. A dark lamp in the press cycle is always judged as idle,
    // which also covers LOCKED/ARMED lamps turning off in that same cycle.
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else if (bus.lights == '0) begin
            state_d = S_IDLE;
            miss_d  = (|press_q) & MISS_ON_IDLE;
        end else if (state_q == S_LOCKED) begin
            miss_d  = |press_q;
        end else begin
            state_d = S_ARMED;
            // Any wrong button wins over a right one, so mashing never scores
            if ((press_q & ~bus.lights) != '0) begin
                miss_d  = 1'b1;
                state_d = S_LOCKED;
            end else if ((press_q & bus.lights) != '0) begin
                hit_d   = 1'b1;
                state_d = S_LOCKED;
            end
        end
    end

    // State, result pulses and saturating counters (clear beats increment)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            hit_pos_q <= '0;
            score_q   <= '0;
            misses_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            if (hit_d || miss_d) hit_pos_q <= lowest_idx(press_q);
            if (bus.clear_score) begin
                score_q  <= '0;
                misses_q <= '0;
            end else begin
                if (hit_d && (score_q != '1))   score_q  <= score_q + SCORE_W'(1);
                if (miss_d && (misses_q != '1)) misses_q <= misses_q + SCORE_W'(1);
            end
        end
    end

    assign bus.hit     = hit_q;
    assign bus.miss    = miss_q;
    assign bus.hit_pos = hit_pos_q;
    assign bus.score   = score_q;
    assign bus.misses  = misses_q;
endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector. Three instances share one stimulus:
//   u_a : DEBOUNCE_CYCLES=4, SCORE_W=8, MISS_ON_IDLE=1
//   u_s : DEBOUNCE_CYCLES=4, SCORE_W=2, MISS_ON_IDLE=1
//   u_n : DEBOUNCE_CYCLES=4, SCORE_W=8, MISS_ON_IDLE=0
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hit_detector;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clear_score;
    logic [8:0] buttons;
    logic [8:0] lights;
    int         n_cmp;
    int         n_err;
    logic       seen;

    hit_detector_if #(.SCORE_W(8)) bus_a ();
    hit_detector_if #(.SCORE_W(2)) bus_s ();
    hit_detector_if #(.SCORE_W(8)) bus_n ();

    assign bus_a.enable      = enable;
    assign bus_a.clear_score = clear_score;
    assign bus_a.buttons     = buttons;
    assign bus_a.lights      = lights;
    assign bus_s.enable      = enable;
    assign bus_s.clear_score = clear_score;
    assign bus_s.buttons     = buttons;
    assign bus_s.lights      = lights;
    assign bus_n.enable      = enable;
    assign bus_n.clear_score = clear_score;
    assign bus_n.buttons     = buttons;
    assign bus_n.lights      = lights;

    hit_detector #(.DEBOUNCE_CYCLES(16'd4), .SCORE_W(8), .MISS_ON_IDLE(1'b1))
        u_a (.clk(clk), .reset(rst_n), .bus(bus_a));
    hit_detector #(.DEBOUNCE_CYCLES(16'd4), .SCORE_W(2), .MISS_ON_IDLE(1'b1))
        u_s (.clk(clk), .reset(rst_n), .bus(bus_s));
    hit_detector #(.DEBOUNCE_CYCLES(16'd4), .SCORE_W(8), .MISS_ON_IDLE(1'b0))
        u_n (.clk(clk), .reset(rst_n), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b1; enable = 1'b0; clear_score = 1'b0;
        buttons = '0; lights = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_hit",     32'(bus_a.hit), 0);
        check("rst_miss",    32'(bus_a.miss), 0);
        check("rst_hit_pos", 32'(bus_a.hit_pos), 0);
        check("rst_score",   32'(bus_a.score), 0);
        check("rst_misses",  32'(bus_a.misses), 0);

        // 1: held press on the lit lamp -> hit at edge 7
        rst_n = 1'b1; enable = 1'b1; lights = 9'h010;
        cyc(2);
        buttons = 9'h010;
        cyc(6);
        check("s1_hit_early", 32'(bus_a.hit), 0);
        cyc(1);
        check("s1_hit",     32'(bus_a.hit), 1);
        check("s1_miss",    32'(bus_a.miss), 0);
        check("s1_score",   32'(bus_a.score), 1);
        check("s1_hit_pos", 32'(bus_a.hit_pos), 4);
        cyc(1);
        check("s1_hit_1cyc", 32'(bus_a.hit), 0);
        buttons = '0;
        cyc(10);

        // 2: three-cycle glitch is filtered out
        buttons = 9'h004;
        cyc(3);
        buttons = '0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            seen = seen | bus_a.hit | bus_a.miss;
        end
        check("s2_no_pulse", 32'(seen), 0);
        check("s2_score",    32'(bus_a.score), 1);
        check("s2_misses",   32'(bus_a.misses), 0);

        // 3: right and wrong button together -> miss, then LOCKED
        lights = '0;
        cyc(1);
        lights = 9'h010; buttons = 9'h030;
        cyc(7);
        check("s3_miss",    32'(bus_a.miss), 1);
        check("s3_hit",     32'(bus_a.hit), 0);
        check("s3_misses",  32'(bus_a.misses), 1);
        check("s3_hit_pos", 32'(bus_a.hit_pos), 4);
        buttons = '0;
        cyc(10);
        buttons = 9'h010;
        cyc(7);
        check("s3_locked_miss", 32'(bus_a.miss), 1);
        check("s3_locked_hit",  32'(bus_a.hit), 0);
        check("s3_misses2",     32'(bus_a.misses), 2);
        buttons = '0;
        cyc(10);

        // 4: hit, repeat strike -> miss, new lamp -> hit
        lights = '0;
        cyc(1);
        lights = 9'h010; buttons = 9'h010;
        cyc(7);
        check("s4_hit",   32'(bus_a.hit), 1);
        check("s4_score", 32'(bus_a.score), 2);
        buttons = '0;
        cyc(10);
        buttons = 9'h010;
        cyc(7);
        check("s4_again_miss", 32'(bus_a.miss), 1);
        check("s4_again_hit",  32'(bus_a.hit), 0);
        check("s4_misses",     32'(bus_a.misses), 3);
        buttons = '0;
        cyc(10);
        lights = '0;
        cyc(1);
        lights = 9'h001; buttons = 9'h001;
        cyc(7);
        check("s4_new_hit",     32'(bus_a.hit), 1);
        check("s4_new_score",   32'(bus_a.score), 3);
        check("s4_new_hit_pos", 32'(bus_a.hit_pos), 0);
        buttons = '0;
        cyc(10);

        // 5: 2-bit score saturates at 3; clear beats the 5th increment
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("s5_rst_score", 32'(bus_s.score), 0);
        for (int k = 1; k <= 4; k++) begin
            lights = '0;
            cyc(1);
            lights = 9'h002; buttons = 9'h002;
            cyc(7);
            check("s5_hit",   32'(bus_s.hit), 1);
            check("s5_score", 32'(bus_s.score), (k < 3) ? 32'(k) : 32'd3);
            buttons = '0;
            cyc(10);
        end
        lights = '0;
        cyc(1);
        lights = 9'h002; buttons = 9'h002;
        cyc(6);
        clear_score = 1'b1;
        cyc(1);
        check("s5_clr_hit",     32'(bus_s.hit), 1);
        check("s5_clr_score",   32'(bus_s.score), 0);
        check("s5_clr_score_a", 32'(bus_a.score), 0);
        clear_score = 1'b0;
        buttons = '0;
        cyc(10);

        // 6: idle press per MISS_ON_IDLE, disabled game, async reset mid-hold
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        lights = '0; buttons = 9'h008;
        cyc(7);
        check("s6_n_miss",   32'(bus_n.miss), 0);
        check("s6_n_misses", 32'(bus_n.misses), 0);
        check("s6_a_miss",   32'(bus_a.miss), 1);
        check("s6_a_misses", 32'(bus_a.misses), 1);
        buttons = '0;
        cyc(10);
        enable = 1'b0; lights = 9'h008; buttons = 9'h008;
        cyc(7);
        check("s6_dis_hit",   32'(bus_a.hit), 0);
        check("s6_dis_miss",  32'(bus_a.miss), 0);
        check("s6_dis_score", 32'(bus_a.score), 0);
        buttons = '0;
        cyc(10);
        enable = 1'b1; lights = '0;
        cyc(1);
        lights = 9'h008; buttons = 9'h008;
        cyc(7);
        check("s6_hit",     32'(bus_a.hit), 1);
        check("s6_score",   32'(bus_a.score), 1);
        check("s6_hit_pos", 32'(bus_a.hit_pos), 3);
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        check("s6_arst_score",   32'(bus_a.score), 0);
        check("s6_arst_hit_pos", 32'(bus_a.hit_pos), 0);
        check("s6_arst_misses",  32'(bus_a.misses), 0);
        check("s6_arst_hit",     32'(bus_a.hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(6);
        check("s6_requal_early", 32'(bus_a.hit), 0);
        cyc(1);
        check("s6_requal_hit",   32'(bus_a.hit), 1);
        check("s6_requal_score", 32'(bus_a.score), 1);
        buttons = '0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
